// File: rtl/mem_defs.sv
// Shared definitions for the stalling memory responder.
package mem_defs;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, registered read on a read strobe.
// Contents are deliberately not reset.
module mem_word_array
  import mem_defs::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // Write commits and read captures both happen on the strobed edge.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/stall_mem_resp.sv
// Multi-cycle memory responder: accepts one word read/write, stalls the
// requester for LATENCY cycles, then pulses done for one cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; a request on the next edge is accepted
// ST_BUSY | transaction in flight, cnt counts down to the access edge
// ST_RESP | done cycle; accepts a new request just like ST_IDLE
module stall_mem_resp
  import mem_defs::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [15:0]       data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [15:0]       data_out,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  done_n, stall_n, err_n;
  logic                  take;
  logic                  req, illegal, fire;
  logic                  mem_we, mem_re;
  logic                  rd_seen;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  op_wr_q;
  logic [WORD_W-1:0]     mem_rdata;

  // Address bits above the word index alias onto the same storage.
  if (DEPTH_LOG2 + 1 < 16) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^addr[15:DEPTH_LOG2+1];
  end

  assign req     = rd | wr;
  assign illegal = (rd & wr) | addr[0];
  assign fire    = (state == ST_BUSY) && (cnt == '0);
  assign mem_we  = fire & op_wr_q;
  assign mem_re  = fire & ~op_wr_q;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    stall_n = stall;
    take    = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        state_n = ST_IDLE;
        stall_n = 1'b0;
        if (req) begin
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            take    = 1'b1;
            state_n = ST_BUSY;
            cnt_n   = CNT_INIT;
            stall_n = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = ST_RESP;
          done_n  = 1'b1;
          stall_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        stall_n = 1'b0;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      stall   <= 1'b0;
      err     <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      stall <= stall_n;
      err   <= err_n;
      if (mem_re) rd_seen <= 1'b1;
    end
  end

  // Latched request copies; later input changes are ignored until done.
  always_ff @(posedge clk) begin
    if (take) begin
      idx_q   <= addr[DEPTH_LOG2:1];
      wdata_q <= data_in;
      op_wr_q <= wr;
    end
  end

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // The array's read register has no reset, so data_out reads as zero
  // until the first read completes; afterwards it holds the last read.
  assign data_out = rd_seen ? mem_rdata : '0;

endmodule

// File: tb/tb_stall_mem_resp.sv
// Bench for stall_mem_resp: table-driven transactions with a scoreboard,
// plus hand sequences for back-to-back, reset and LATENCY=1 cases.
module tb_stall_mem_resp;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic        clk, rst;
  logic [15:0] addr, din;
  logic        rd, wr, sel;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] data0, data1, o_data;
  logic        done0, stall0, err0, done1, stall1, err1;
  logic        o_done, o_stall, o_err;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t tbl4[9];
  vec_t tbl1[4];

  assign rd0 = rd & ~sel;
  assign wr0 = wr & ~sel;
  assign rd1 = rd & sel;
  assign wr1 = wr & sel;

  assign o_data  = sel ? data1  : data0;
  assign o_done  = sel ? done1  : done0;
  assign o_stall = sel ? stall1 : stall0;
  assign o_err   = sel ? err1   : err0;

  stall_mem_resp #(.DEPTH_LOG2(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(din), .rd(rd0), .wr(wr0),
    .data_out(data0), .done(done0), .stall(stall0), .err(err0)
  );

  stall_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(din), .rd(rd1), .wr(wr1),
    .data_out(data1), .done(done1), .stall(stall1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one transaction from IDLE, wait for done/err, check and release.
  task automatic run_txn(input vec_t v, input int lat);
    exp_t e;
    int   edges, stalls;
    logic seen;
    exp_q.push_back('{v.exp_err, v.exp_data});
    rd = v.rd; wr = v.wr; addr = v.addr; din = v.din;
    edges = 0; stalls = 0; seen = 1'b0;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_done || o_err) seen = 1'b1;
    end
    rd = 1'b0; wr = 1'b0;
    e = exp_q.pop_front();
    chk("completion_seen", {31'd0, seen}, 1);
    if (seen) begin
      chk("err", {31'd0, o_err}, {31'd0, e.err});
      chk("done", {31'd0, o_done}, {31'd0, ~e.err});
      chk("edges_to_result", edges, e.err ? 1 : lat + 1);
      chk("stall_cycles", stalls, e.err ? 0 : lat);
      chk("data_out", {16'd0, o_data}, {16'd0, e.data});
      @(negedge clk);
      chk("pulse_ends", {29'd0, o_done, o_err, o_stall}, 0);
    end
  endtask

  initial begin
    exp_t e;
    int   edges, ndone;
    logic seen;

    tbl4[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000};
    tbl4[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
    tbl4[2] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h1234};
    tbl4[3] = '{1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b1, 16'h1234};
    tbl4[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
    tbl4[5] = '{1'b0, 1'b1, 16'h0012, 16'hABCD, 1'b0, 16'h1234};
    tbl4[6] = '{1'b0, 1'b1, 16'h0202, 16'h5555, 1'b0, 16'h1234};
    tbl4[7] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h5555};
    tbl4[8] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h5555};

    tbl1[0] = '{1'b0, 1'b1, 16'h0202, 16'h5555, 1'b0, 16'h0000};
    tbl1[1] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h5555};
    tbl1[2] = '{1'b0, 1'b1, 16'h0010, 16'h7777, 1'b0, 16'h5555};
    tbl1[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h7777};

    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_l4", {13'd0, done0, stall0, err0, data0}, 0);
    chk("reset_outputs_l1", {13'd0, done1, stall1, err1, data1}, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(tbl4[i], 4);

    // Back-to-back reads: second request presented during the RESP cycle.
    exp_q.push_back('{1'b0, 16'h1234});
    exp_q.push_back('{1'b0, 16'hABCD});
    rd = 1'b1; addr = 16'h0010;
    ndone = 0; seen = 1'b0;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(negedge clk);
      if (o_done) begin ndone++; seen = 1'b1; end
    end
    e = exp_q.pop_front();
    chk("b2b_first_seen", {31'd0, seen}, 1);
    chk("b2b_first_data", {16'd0, o_data}, {16'd0, e.data});
    addr = 16'h0012;
    edges = 0; seen = 1'b0;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) chk("b2b_no_bubble_stall", {31'd0, o_stall}, 1);
      if (o_done) begin ndone++; seen = 1'b1; end
    end
    rd = 1'b0;
    e = exp_q.pop_front();
    chk("b2b_second_seen", {31'd0, seen}, 1);
    chk("b2b_edges", edges, 5);
    chk("b2b_second_data", {16'd0, o_data}, {16'd0, e.data});
    repeat (2) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("b2b_done_count", ndone, 2);

    // Asynchronous reset mid-cycle while a read is in flight.
    rd = 1'b1; addr = 16'h0012;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_stall", {31'd0, o_stall}, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {13'd0, o_done, o_stall, o_err, o_data}, 0);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset aborts an uncommitted write (cnt==2 after the second edge).
    wr = 1'b1; addr = 16'h0020; din = 16'hBEEF;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wr = 1'b0;
    #1 chk("abort_stall_cleared", {31'd0, o_stall}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn('{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000}, 4);
    run_txn('{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'hABCD}, 4);

    // LATENCY=1 instance.
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) run_txn(tbl1[i], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
